// File: rtl/fixed_to_float_seq.sv
// Iterative 32-bit two's-complement fixed-point (1 integer bit, 30 fraction bits)
// to IEEE-754 single converter: one normalising shift per clock, RNE rounding.
module fixed_to_float_seq #(
  parameter int unsigned W    = 32,
  parameter int unsigned FRAC = 30
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         START,
  input  logic [W-1:0] FIXED,
  output logic         BUSY,
  output logic         DONE,
  output logic [W-1:0] FLOAT
);

  // Biased exponent of a value whose leading one sits at bit W-1.
  localparam int unsigned EXP_TOP = 127 + (W - 1 - FRAC);

  typedef enum logic [1:0] {S_IDLE, S_NORM, S_ROUND} state_t;

  state_t       r_state, w_state_nxt;
  logic         r_sign,  w_sign_nxt;
  logic         r_zero,  w_zero_nxt;
  logic [W-1:0] r_mag,   w_mag_nxt;
  logic [4:0]   r_cnt,   w_cnt_nxt;
  logic         r_busy,  w_busy_nxt;
  logic         r_done,  w_done_nxt;
  logic [W-1:0] r_float, w_float_nxt;

  logic [W-1:0] w_abs;
  logic [22:0]  w_mant;
  logic         w_guard;
  logic         w_sticky;
  logic         w_rnd;
  logic [23:0]  w_mant_sum;
  logic [7:0]   w_exp;
  logic [W-1:0] w_result;

  // Most negative input maps to magnitude 0x80000000 as an unsigned value.
  assign w_abs = FIXED[W-1] ? (~FIXED + W'(1)) : FIXED;

  assign w_mant     = r_mag[30:8];
  assign w_guard    = r_mag[7];
  assign w_sticky   = |r_mag[6:0];
  assign w_rnd      = w_guard & (w_sticky | w_mant[0]);
  assign w_mant_sum = {1'b0, w_mant} + {23'b0, w_rnd};
  // A carry out of the mantissa leaves sum[22:0] already zero; only bump the exponent.
  assign w_exp      = 8'(EXP_TOP) - {3'b0, r_cnt} + {7'b0, w_mant_sum[23]};
  assign w_result   = {r_sign, w_exp, w_mant_sum[22:0]};

  always_comb begin
    w_state_nxt = r_state;
    w_sign_nxt  = r_sign;
    w_zero_nxt  = r_zero;
    w_mag_nxt   = r_mag;
    w_cnt_nxt   = r_cnt;
    w_busy_nxt  = r_busy;
    w_done_nxt  = 1'b0;
    w_float_nxt = r_float;
    case (r_state)
      S_IDLE: begin
        if (START) begin
          w_sign_nxt  = FIXED[W-1];
          w_mag_nxt   = w_abs;
          w_cnt_nxt   = '0;
          w_zero_nxt  = 1'b0;
          w_busy_nxt  = 1'b1;
          w_state_nxt = S_NORM;
        end
      end
      S_NORM: begin
        if (r_mag == '0) begin
          w_zero_nxt  = 1'b1;
          w_state_nxt = S_ROUND;
        end else if (r_mag[W-1]) begin
          w_state_nxt = S_ROUND;
        end else begin
          w_mag_nxt = {r_mag[W-2:0], 1'b0};
          w_cnt_nxt = r_cnt + 5'd1;
        end
      end
      S_ROUND: begin
        w_float_nxt = r_zero ? '0 : w_result;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= S_IDLE;
      r_sign  <= 1'b0;
      r_zero  <= 1'b0;
      r_mag   <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_float <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_sign  <= w_sign_nxt;
      r_zero  <= w_zero_nxt;
      r_mag   <= w_mag_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      r_float <= w_float_nxt;
    end
  end

  assign BUSY  = r_busy;
  assign DONE  = r_done;
  assign FLOAT = r_float;

endmodule

// File: tb/tb_fixed_to_float_seq.sv
// Scoreboard bench for fixed_to_float_seq: stimulus pushes expected result and
// accept cycle, a forked monitor checks FLOAT and latency on every DONE.
module tb_fixed_to_float_seq;

  logic        CLK;
  logic        RST;
  logic        START;
  logic [31:0] FIXED;
  logic        BUSY;
  logic        DONE;
  logic [31:0] FLOAT;

  fixed_to_float_seq #(.W(32), .FRAC(30)) dut (
    .CLK  (CLK),
    .RST  (RST),
    .START(START),
    .FIXED(FIXED),
    .BUSY (BUSY),
    .DONE (DONE),
    .FLOAT(FLOAT)
  );

  typedef struct {
    logic [31:0] f;
    int          lat;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %08h, required %08h", name, act, req);
    end
  endtask

  // Independent reference: locate the leading one, then round the tail to nearest-even.
  function automatic void model(input logic [31:0] v, output logic [31:0] f, output int lat);
    logic            s;
    longint unsigned m, sig, rem, half;
    int              p, k;
    s = v[31];
    m = s ? (64'h1_0000_0000 - {32'b0, v}) : {32'b0, v};
    if (m == 0) begin
      f   = 32'h0;
      lat = 2;
      return;
    end
    p = 0;
    for (int i = 0; i < 32; i++) if (m[i]) p = i;
    lat = 31 - p + 2;
    if (p <= 23) begin
      sig = m << (23 - p);
    end else begin
      k    = p - 23;
      sig  = m >> k;
      rem  = m - (sig << k);
      half = 64'd1 << (k - 1);
      if (rem > half || (rem == half && sig[0])) sig++;
    end
    if (sig == (64'd1 << 24)) begin
      sig = sig >> 1;
      p++;
    end
    f = {s, 8'(127 + p - 30), sig[22:0]};
  endfunction

  // Waits (bounded) for an idle cycle, pulses START with v; returns at the
  // falling edge after the accepting edge.
  task automatic issue(input logic [31:0] v, input logic [31:0] f, input int lat, input bit push);
    exp_t e;
    int   k;
    k = 0;
    while (BUSY && k < 100) begin
      @(negedge CLK);
      k++;
    end
    if (BUSY) begin
      total++;
      bad++;
      $display("FAIL idle_wait: BUSY still 1 after %0d cycles, required 0", k);
    end
    START = 1'b1;
    FIXED = v;
    if (push) begin
      e.f = f; e.lat = lat; e.acc = cyc + 1;
      q.push_back(e);
    end
    @(negedge CLK);
    START = 1'b0;
    FIXED = $urandom;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (q.size() > 0 && k < 200) begin
      @(negedge CLK);
      k++;
    end
    if (q.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  task automatic run_vec(input logic [31:0] v, input logic [31:0] f, input int lat);
    issue(v, f, lat, 1'b1);
    drain();
  endtask

  initial begin
    logic [31:0] vec_in  [9];
    logic [31:0] vec_out [9];
    int          vec_lat [9];
    logic [31:0] mf, v, ra, rb;
    int          ml, k;
    bit          busy_ok, took;
    exp_t        e;

    vec_in  = '{32'hC000_0000, 32'h8000_0000, 32'h4000_0040, 32'h0000_0000, 32'h4000_00C0,
                32'h7FFF_FFFF, 32'h2000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vec_out = '{32'hBF80_0000, 32'hC000_0000, 32'h3F80_0000, 32'h0000_0000, 32'h3F80_0002,
                32'h4000_0000, 32'h3F00_0000, 32'hB080_0000, 32'h0000_0000};
    vec_lat = '{3, 2, 3, 2, 3, 3, 4, 33, 2};

    fork
      begin : monitor
        logic [31:0] last;
        logic        prev_done;
        exp_t        m;
        last      = 32'h0;
        prev_done = 1'b0;
        forever begin
          @(negedge CLK);
          if (!RST) begin
            last      = 32'h0;
            prev_done = 1'b0;
          end else begin
            if (DONE) begin
              chk("done_width", {31'b0, prev_done}, 32'h0);
              total++;
              if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_done: DONE with FLOAT=%08h, required no DONE", FLOAT);
              end else begin
                m = q.pop_front();
                chk("float", FLOAT, m.f);
                chk("latency", 32'(cyc - m.acc), 32'(m.lat));
              end
              last = FLOAT;
            end else begin
              chk("float_hold", FLOAT, last);
            end
            prev_done = DONE;
          end
        end
      end
    join_none

    RST   = 1'b0;
    START = 1'b0;
    FIXED = 32'h0;
    repeat (3) @(negedge CLK);
    chk("reset_busy",  {31'b0, BUSY}, 32'h0);
    chk("reset_done",  {31'b0, DONE}, 32'h0);
    chk("reset_float", FLOAT, 32'h0);
    RST = 1'b1;
    @(negedge CLK);

    // Reset mid-run: establish a nonzero FLOAT first so the clear is visible.
    run_vec(32'h4000_0000, 32'h3F80_0000, 3);
    issue(32'h0000_0001, 32'h0, 0, 1'b0);
    repeat (4) @(negedge CLK);
    RST = 1'b0;
    #1;
    chk("abort_busy",  {31'b0, BUSY}, 32'h0);
    chk("abort_done",  {31'b0, DONE}, 32'h0);
    chk("abort_float", FLOAT, 32'h0);
    @(negedge CLK);
    RST = 1'b1;
    repeat (40) @(negedge CLK);
    run_vec(32'h4000_0000, 32'h3F80_0000, 3);

    for (int i = 0; i < 9; i++) run_vec(vec_in[i], vec_out[i], vec_lat[i]);

    // Longest path with BUSY observed on every cycle of the conversion.
    issue(32'h0000_0001, 32'h3080_0000, 33, 1'b1);
    busy_ok = 1'b1;
    for (int i = 0; i < 33; i++) begin
      if (!BUSY) busy_ok = 1'b0;
      if (i < 32) @(negedge CLK);
    end
    chk("long_busy", {31'b0, busy_ok}, 32'h1);
    drain();

    // START held high: second operand may only be taken on the DONE cycle.
    START = 1'b1;
    FIXED = 32'h0000_1000;
    e.f = 32'h3680_0000; e.lat = 21; e.acc = cyc + 1;
    q.push_back(e);
    took = 1'b0;
    k = 0;
    while (!took && k < 100) begin
      @(negedge CLK);
      k++;
      if (!BUSY) begin
        FIXED = 32'hC000_0000;
        e.f = 32'hBF80_0000; e.lat = 3; e.acc = cyc + 1;
        q.push_back(e);
        took = 1'b1;
      end else begin
        FIXED = $urandom;
      end
    end
    chk("held_start_idle", {31'b0, took}, 32'h1);
    @(negedge CLK);
    START = 1'b0;
    drain();

    // START pulse while BUSY must be dropped.
    issue(32'h0000_0100, 32'h3480_0000, 25, 1'b1);
    repeat (3) @(negedge CLK);
    START = 1'b1;
    FIXED = 32'h7FFF_FFFF;
    @(negedge CLK);
    START = 1'b0;
    drain();
    repeat (10) @(negedge CLK);

    for (int i = 0; i < 10000; i++) begin
      v = $urandom;
      model(v, mf, ml);
      issue(v, mf, ml, 1'b1);
    end
    for (int i = 0; i < 300; i++) begin
      ra = $urandom;
      rb = ra >> $urandom_range(0, 31);
      v  = ($urandom_range(0, 1) == 1) ? (~rb + 32'd1) : rb;
      model(v, mf, ml);
      issue(v, mf, ml, 1'b1);
    end
    drain();
    repeat (5) @(negedge CLK);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fixed_to_float_seq.md
# fixed_to_float_seq

Sequential converter from the 32-bit two's-complement fixed-point word produced by the float-to-fixed datapath and the fixed-point arithmetic stages back to IEEE-754 single precision. It sits directly downstream of those stages and returns results to the floating-point domain. Normalisation is iterative: one left shift per clock, controlled by an internal FSM with a START/DONE handshake. Rounding is round-to-nearest-even.

## Interface
- W, 32, fixed-point word width; only 32 is supported.
- FRAC, 30, number of fraction bits. The format is sign bit 31, integer bit 30, binary point between bits 30 and 29.

- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous reset, active-low. One clock; reset is asynchronous and active-low.
- START  in  1  conversion request; sampled only when BUSY=0.
- FIXED  in  32  two's-complement fixed-point operand; sampled at the START edge only.
- BUSY  out  1  high from the accepting edge until the edge that asserts DONE.
- DONE  out  1  one-cycle pulse; FLOAT is valid from this cycle on.
- FLOAT  out  32  IEEE-754 result, registered; holds until the next DONE.

## Operation
- FSM states: IDLE, NORM, ROUND.
- IDLE, START=1:
  - capture SIGN=FIXED[31] and MAG=|FIXED| (32-bit unsigned);
  - clear shift counter CNT (5 bits);
  - set BUSY=1 and go to NORM.
  - 0x80000000 gives MAG=0x80000000 with no overflow.
- NORM:
  - if MAG==0, set ZERO flag and go to ROUND;
  - else if MAG[31]=1, go to ROUND;
  - else MAG<<=1 and CNT+=1.
  - CNT can never exceed 31.
- ROUND:
  - exponent E = 128 − CNT (range 97..128);
  - mantissa M = MAG[30:8]; guard G = MAG[7]; sticky S = |MAG[6:0];
  - round up when G & (S | M[0]);
  - if the increment carries out of 23 bits, set M=0 and E+=1 (max 129; overflow is impossible).
  - FLOAT <= {SIGN, E[7:0], M}.
  - ZERO forces FLOAT <= 0x00000000 (positive zero, regardless of SIGN).
  - DONE <= 1, BUSY <= 0, go to IDLE.
- START while BUSY=1 is ignored and not queued.
- START in the same cycle DONE is high is accepted (state is IDLE), so back-to-back conversion is supported.
- Denormals, infinities and NaN cannot be produced. The exponent range is fixed by the format.

## Timing
- Reset values: BUSY=0, DONE=0, FLOAT=0x00000000, state IDLE, internal registers 0.
- Reset asserted mid-conversion aborts it immediately. No DONE is produced for the aborted request.
- Latency: START accepted at edge t0; DONE high after edge t0+n+2, where n = leading-zero count of MAG (0..31).
  - Zero operand: n treated as 0, so latency is 2.
  - Minimum latency 2 cycles, maximum 33.
- DONE is exactly one cycle wide.
- FLOAT changes only on the edge that raises DONE (or on reset).
- FIXED may change freely after the accepting edge.

## Test plan
- Reset mid-run: START with FIXED=0x00000001, pull RST low on cycle 5 -> BUSY=0, DONE never pulses, FLOAT=0x00000000. Then START with FIXED=0x40000000 -> FLOAT=0x3F800000, DONE at t0+3.
- Signs and extremes:
  - FIXED=0xC0000000 -> 0xBF800000, latency 3.
  - FIXED=0x80000000 -> 0xC0000000 (−2.0), latency 2.
  - FIXED=0x00000000 -> 0x00000000, latency 2.
- Longest path: FIXED=0x00000001 -> FLOAT=0x30800000 (2^−30), DONE at t0+33; BUSY high for all 33 cycles.
- Rounding:
  - FIXED=0x40000040 (tie, even LSB) -> 0x3F800000;
  - FIXED=0x400000C0 (tie, odd LSB) -> 0x3F800002;
  - FIXED=0x7FFFFFFF (carry out) -> 0x40000000.
- Handshake:
  - START held high throughout a conversion -> the second operand is accepted only on the DONE cycle;
  - a second START pulse while BUSY=1 -> ignored, FLOAT reflects the first operand only.
- Random: 10k random FIXED values checked against a reference model. Both FLOAT and latency n+2 must match.
